// File: rtl/sram_like_responder.sv
// SRAM-like req/addr_ok/data_ok responder: word memory plus an in-order response queue.
// Define SRAM_RAND_STALL_EN to add LFSR-driven random back-pressure on accept and response.
module sram_like_responder #(
    parameter int          MEM_AW    = 12,
    parameter int          DEPTH     = 4,
    parameter int          LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    logic [31:0]       mem_q   [0:(1<<MEM_AW)-1];
    logic [31:0]       qdata_q [0:DEPTH-1];
    logic [3:0]        age_q   [0:DEPTH-1];
    logic [3:0]        age_d   [0:DEPTH-1];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [31:0]       last_q, last_d;
    logic [MEM_AW-1:0] idx;
    logic              accept, ready, acc_en, pop_en;
    logic              unused_ok;

    assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};
    assign idx       = addr[MEM_AW+1:2];

`ifdef SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign acc_en = lfsr_q[0];
    assign pop_en = lfsr_q[1];
`else
    assign acc_en = 1'b1;
    assign pop_en = 1'b1;
`endif

    // Count only drops after the response cycle, so a same-cycle pop never frees a slot early.
    assign addr_ok = req && (cnt_q < FULL) && acc_en;
    assign accept  = addr_ok;
    assign ready   = (cnt_q != '0) && (age_q[rptr_q] >= LAT);
    assign data_ok = ready && pop_en;
    assign rdata   = data_ok ? qdata_q[rptr_q] : last_q;

    always_comb begin
        wptr_d = accept  ? wptr_q + PW'(1) : wptr_q;
        rptr_d = data_ok ? rptr_q + PW'(1) : rptr_q;
        last_d = data_ok ? qdata_q[rptr_q] : last_q;
        cnt_d  = cnt_q;
        if (accept && !data_ok)      cnt_d = cnt_q + (PW+1)'(1);
        else if (!accept && data_ok) cnt_d = cnt_q - (PW+1)'(1);
    end

    // Age counts cycles since the accept edge, so a push starts at 1 and saturates at LATENCY.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (age_q[i] < LAT) age_d[i] = age_q[i] + 4'd1;
        end
        if (accept) age_d[wptr_q] = 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    // Memory and queued read data are not reset; reads sample the pre-write word at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            qdata_q[wptr_q] <= wr ? 32'h0 : mem_q[idx];
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench for sram_like_responder: two instances (LATENCY 1 and 5) checked by a
// negedge monitor against a queue of expected {rdata, due cycle} pushed at each accept.
module tb_sram_like_responder;
    localparam int LAT_A = 1;
    localparam int LAT_B = 5;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [3:0]  wstrb [2];
    logic [31:0] wdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata [2];

    logic [31:0] mdl [2][4096];
    exp_t        exp0 [$];
    exp_t        exp1 [$];
    logic [31:0] last_rd0 = 32'h0;
    logic [31:0] last_rd1 = 32'h0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    sram_like_responder #(.MEM_AW(12), .DEPTH(4), .LATENCY(LAT_A), .LFSR_SEED(16'hACE1)) u_a (
        .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
        .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
        .rdata(rdata[0]));

    sram_like_responder #(.MEM_AW(12), .DEPTH(4), .LATENCY(LAT_B), .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
        .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
        .rdata(rdata[1]));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic sb_pop(input int d, input logic [31:0] got);
        exp_t e;
        int   sz;
        sz = (d == 0) ? exp0.size() : exp1.size();
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL resp_unexpected dut%0d cyc=%0d rdata=%h expected no response", d, cyc, got);
            return;
        end
        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        if (got !== e.data) begin
            errors++;
            $display("FAIL resp_data dut%0d cyc=%0d rdata=%h expected %h", d, cyc, got, e.data);
        end
        checks++;
`ifdef SRAM_RAND_STALL_EN
        if (cyc < int'(e.due)) begin
`else
        if (cyc != int'(e.due)) begin
`endif
            errors++;
            $display("FAIL resp_cycle dut%0d cyc=%0d expected %0d", d, cyc, e.due);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (resetn) begin
            if (data_ok[0]) begin
                sb_pop(0, rdata[0]);
                last_rd0 = rdata[0];
            end
            if (data_ok[1]) begin
                sb_pop(1, rdata[1]);
                last_rd1 = rdata[1];
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, output int acc);
        int   n;
        int   ix;
        exp_t e;
        n = 0;
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = wd; size[d] = 2'd2;
        @(negedge clk);
        while (!addr_ok[d] && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!addr_ok[d]) begin
            errors++;
            $display("FAIL accept_timeout dut%0d addr=%h addr_ok=0 expected 1", d, a);
            acc = -1;
            req[d] = 1'b0;
            return;
        end
        acc = cyc;
        ix = int'(a[13:2]);
        e.due = 32'(cyc + ((d == 0) ? LAT_A : LAT_B));
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][ix][8*b +: 8] = wd[8*b +: 8];
            e.data = 32'h0;
        end else begin
            e.data = mdl[d][ix];
        end
        if (d == 0) exp0.push_back(e);
        else        exp1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        req[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? exp0.size() : exp1.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((d == 0) ? exp0.size() : exp1.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d outstanding=%0d expected 0", d,
                     (d == 0) ? exp0.size() : exp1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected %h", name, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int s;
        int ab [6];
        int n;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd2; addr[d] = '0; wstrb[d] = '0; wdata[d] = '0;
        end
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data_ok_a", 32'(data_ok[0]), 32'h0);
        chk("reset_data_ok_b", 32'(data_ok[1]), 32'h0);
        chk("reset_rdata_a", rdata[0], 32'h0);
        chk("reset_rdata_b", rdata[1], 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fetch-style read at LATENCY 1 from the reset vector
        issue(0, 1'b1, 32'h1c000000, 4'hf, 32'h02800c0c, acc);
        idle(0);
        drain(0);
        s = cyc;
        issue(0, 1'b0, 32'h1c000000, 4'h0, 32'h0, acc);
        idle(0);
`ifndef SRAM_RAND_STALL_EN
        chk("t1_accept_same_cycle", 32'(acc), 32'(s));
`endif
        drain(0);
        chk("t1_rdata", last_rd0, 32'h02800c0c);

        // Partial-strobe write followed by read of the same word
        issue(0, 1'b1, 32'h10, 4'hf, 32'h11223344, acc);
        issue(0, 1'b1, 32'h10, 4'b0011, 32'hAABBCCDD, acc);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, acc);
        idle(0);
        drain(0);
        chk("t2_merged_read", last_rd0, 32'h1122CCDD);

        // Upper address bits alias onto word 0
        issue(0, 1'b0, 32'h00004000, 4'h0, 32'h0, acc);
        idle(0);
        drain(0);
        chk("t4_alias_word0", last_rd0, 32'h02800c0c);

        // Fill the LATENCY-5 queue with req held high
        for (int i = 0; i < 8; i++)
            issue(1, 1'b1, 32'(i * 4), 4'hf, 32'h10000000 + 32'(i * 32'h111), acc);
        idle(1);
        drain(1);
        for (int i = 0; i < 6; i++)
            issue(1, 1'b0, 32'(i * 4), 4'h0, 32'h0, ab[i]);
        idle(1);
        drain(1);
`ifndef SRAM_RAND_STALL_EN
        chk("t3_acc1", 32'(ab[1] - ab[0]), 32'd1);
        chk("t3_acc2", 32'(ab[2] - ab[1]), 32'd1);
        chk("t3_acc3", 32'(ab[3] - ab[2]), 32'd1);
        chk("t3_full_stall", 32'(ab[4] - ab[3]), 32'd3);
        chk("t3_acc5", 32'(ab[5] - ab[4]), 32'd1);
`endif
        chk("t3_last_rdata", last_rd1, 32'h10000555);

        // Async reset while a response is on the bus with a second still queued
        issue(1, 1'b0, 32'h0, 4'h0, 32'h0, acc);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, acc);
        idle(1);
        n = 0;
        while (!data_ok[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_resp_seen", 32'(data_ok[1]), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("t5_data_ok_cleared", 32'(data_ok[1]), 32'h0);
        chk("t5_rdata_cleared", rdata[1], 32'h0);
        exp0.delete();
        exp1.delete();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h8, 4'h0, 32'h0, acc);
        idle(1);
        drain(1);
        chk("t5_after_reset_read", last_rd1, 32'h10000222);

        // Mixed random traffic over words 0..7
        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3) << 14);
            issue(1, w, a, 4'($urandom_range(0, 15)), $urandom, acc);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                @(posedge clk);
                #1;
            end
        end
        idle(1);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
